// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - external memory request/acknowledge bundle for mem_ctrl
interface mem_ctrl_if;
    logic [15:0] memAddr;
    logic [15:0] memWData;
    logic        memRdEn;
    logic        memWrEn;
    logic [15:0] memRData;
    logic        memAck;

    modport master (
        output memAddr,
        output memWData,
        output memRdEn,
        output memWrEn,
        input  memRData,
        input  memAck
    );

    modport slave (
        input  memAddr,
        input  memWData,
        input  memRdEn,
        input  memWrEn,
        output memRData,
        output memAck
    );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - LC-3 MAR/MDR memory interface unit; MEM_TIMEOUT_EN adds a request abort timer
module mem_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ldMAR,
    input  logic              ldMDR,
    input  logic              memEN,
    input  logic              memWE,
    input  logic [15:0]       Buss,
    output logic [15:0]       marOut,
    output logic [15:0]       mdrOut,
    output logic              R,
    output logic              busy,
    output logic              memErr,
    mem_ctrl_if.master        mem
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

    state_e      state_q, state_d;
    logic [15:0] mar_q, mar_d;
    logic [15:0] mdr_q, mdr_d;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    // cnt_q holds the number of unacknowledged request cycles already spent
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             err_q, err_d;

    assign cnt_inc = cnt_q + 1'b1;
    assign memErr  = err_q;
`else
    assign memErr  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (ldMAR) mar_d = Buss;
                if (ldMDR) mdr_d = Buss;
                if (memEN) state_d = memWE ? WR : RD;
`ifdef MEM_TIMEOUT_EN
                cnt_d = '0;
`endif
            end
            RD: begin
                if (mem.memAck) begin
                    mdr_d   = mem.memRData;
                    state_d = DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_inc == TIMEOUT_C) begin
                    mdr_d   = 16'h0000;
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
`endif
            end
            WR: begin
                if (mem.memAck) begin
                    state_d = DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_inc == TIMEOUT_C) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
`endif
            end
            // DONE never samples memEN, so a held request cannot retrigger here
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mar_q   <= 16'h0000;
            mdr_q   <= 16'h0000;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign marOut       = mar_q;
    assign mdrOut       = mdr_q;
    assign R            = (state_q == DONE);
    assign busy         = (state_q != IDLE);
    assign mem.memAddr  = mar_q;
    assign mem.memWData = mdr_q;
    assign mem.memRdEn  = (state_q == RD);
    assign mem.memWrEn  = (state_q == WR);

endmodule
